// File: rtl/lsu_mem_access.sv
// Memory-stage load/store unit: one sized access per request over a
// 32-bit req/ack word bus, with alignment checks and a bus timeout.
module lsu_mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  mem_code,
    input  logic        is_store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        misaligned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [2:0]  code_q;
    logic        store_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [7:0]  cnt_q;
    logic        err_q;
    logic        mis_q;

    logic        req_v;
    logic        legal;
    logic        misal;
    logic        wait_s;
    logic [3:0]  be;
    logic [31:0] lane_wdata;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    assign req_v  = start & (mem_code != 3'b000);
    assign wait_s = (state_q == S_WAIT);

    always_comb begin
        legal = 1'b0;
        misal = 1'b0;
        case (mem_code)
            3'b001, 3'b101: legal = 1'b1;
            3'b010, 3'b110: begin
                legal = 1'b1;
                misal = addr[0];
            end
            3'b011: begin
                legal = 1'b1;
                misal = |addr[1:0];
            end
            default: ;
        endcase
    end

    // Size is carried by the low two code bits; bit 2 only selects zero-extension.
    always_comb begin
        be         = 4'b0000;
        lane_wdata = wdata_q;
        case (code_q[1:0])
            2'b01: begin
                be         = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b10: begin
                be         = 4'b0011 << {addr_q[1], 1'b0};
                lane_wdata = {2{wdata_q[15:0]}};
            end
            2'b11: be = 4'b1111;
            default: ;
        endcase
    end

    assign shifted = dmem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = shifted;
        case (code_q)
            3'b001: load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b010: load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101: load_ext = {24'd0, shifted[7:0]};
            3'b110: load_ext = {16'd0, shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            code_q  <= 3'b000;
            store_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_v) begin
                        code_q  <= mem_code;
                        store_q <= is_store;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (!legal || misal) begin
                            state_q <= S_DONE;
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            mis_q   <= legal & misal;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        state_q <= S_DONE;
                        rdata_q <= store_q ? 32'd0 : load_ext;
                        err_q   <= 1'b0;
                        mis_q   <= 1'b0;
                    end else if (cnt_q == TO_LAST) begin
                        state_q <= S_DONE;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        mis_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall      = ((state_q == S_IDLE) & req_v) | wait_s;
    assign done       = (state_q == S_DONE);
    assign rdata      = rdata_q;
    assign err        = err_q;
    assign misaligned = mis_q;
    assign dmem_req   = wait_s;
    assign dmem_we    = wait_s & store_q;
    assign dmem_addr  = wait_s ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dmem_be    = wait_s ? be : 4'b0000;
    assign dmem_wdata = (wait_s & store_q) ? lane_wdata : 32'd0;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Randomized self-checking bench for lsu_mem_access against an
// arithmetic model of sized loads/stores over a word bus.
module tb_lsu_mem_access;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mem_code = 3'b000;
    logic        is_store = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        misaligned;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations of the last access
    logic        o_req, o_we;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_be;
    logic        o_err, o_mis, got_done, stable, done_after;
    int          stall_cyc, req_cyc, lat;

    lsu_mem_access #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mem_code   (mem_code),
        .is_store   (is_store),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .rdata      (rdata),
        .err        (err),
        .misaligned (misaligned),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int nb_of(input logic [2:0] c);
        case (c)
            3'b001, 3'b101: return 1;
            3'b010, 3'b110: return 2;
            3'b011:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic m_err(input logic [2:0] c, input logic [31:0] a);
        int nb = nb_of(c);
        return (nb == 0) || ((a % nb) != 0);
    endfunction

    function automatic logic m_mis(input logic [2:0] c, input logic [31:0] a);
        int nb = nb_of(c);
        return (nb != 0) && ((a % nb) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] c, input logic [31:0] a);
        int nb = nb_of(c);
        return 4'(((1 << nb) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] c, input logic [31:0] wd);
        int nb = nb_of(c);
        longint w = longint'(wd) % (longint'(1) << (8 * nb));
        longint r = 0;
        for (int k = 0; k < 4 / nb; k++) r = r | (w << (8 * nb * k));
        return 32'(r);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] c, input logic st,
                                            input logic [31:0] a, input logic [31:0] rd);
        int nb = nb_of(c);
        longint v;
        if (st) return 32'd0;
        v = (longint'(rd) >> (8 * (a % 4))) % (longint'(1) << (8 * nb));
        if (!c[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        return 32'(v);
    endfunction

    // ---------------- driver / monitor ----------------
    task automatic access(input logic [2:0] c, input logic st, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
        @(negedge clk);
        mem_code = c; is_store = st; addr = a; wdata = wd; start = 1'b1; dmem_ack = 1'b0;
        #1;
        stall_cyc = int'(stall);
        req_cyc = 0; lat = 0; got_done = 1'b0; stable = 1'b1;
        o_req = 1'b0; o_we = 1'b0; o_addr = '0; o_be = '0; o_wdata = '0;
        o_rdata = 32'hDEAD_BEEF; o_err = 1'bx; o_mis = 1'bx;
        for (int cyc = 1; cyc <= TO + 4; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            addr = $urandom; wdata = $urandom;
            mem_code = 3'($urandom); is_store = 1'($urandom);
            if (dmem_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    o_req = dmem_req; o_we = dmem_we; o_addr = dmem_addr;
                    o_be = dmem_be; o_wdata = dmem_wdata;
                end else if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
                             {o_we, o_addr, o_be, o_wdata}) begin
                    stable = 1'b0;
                end
            end
            if (stall) stall_cyc++;
            if (done) begin
                got_done = 1'b1; lat = cyc;
                o_rdata = rdata; o_err = err; o_mis = misaligned;
            end
            if (dmem_req && req_cyc == ack_at) begin
                dmem_ack = 1'b1; dmem_rdata = rd;
            end else begin
                dmem_ack = 1'b0; dmem_rdata = $urandom;
            end
            if (got_done) break;
        end
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        done_after = done;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({stall, done, rdata, err, misaligned, dmem_req, dmem_we,
             dmem_addr, dmem_be, dmem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b done=%b rdata=%h err=%b mis=%b req=%b we=%b addr=%h be=%b wd=%h, want all 0",
                     stall, done, rdata, err, misaligned, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({stall, done, dmem_req, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release: got stall=%b done=%b req=%b err=%b, want 0", stall, done, dmem_req, err);
        end
    endtask

    task automatic test_load_byte;
        access(3'b001, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
        n_tests++;
        if ({o_req, o_we, o_addr, o_be} !== {1'b1, 1'b0, 32'h0000_1000, 4'b1000}) begin
            n_fail++;
            $display("FAIL lb_bus: got req=%b we=%b addr=%h be=%b, want 1 0 00001000 1000", o_req, o_we, o_addr, o_be);
        end
        n_tests++;
        if (lat !== 2 || o_rdata !== 32'hFFFF_FF80 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_result: got lat=%0d rdata=%h err=%b, want 2 ffffff80 0", lat, o_rdata, o_err);
        end
        n_tests++;
        if (done_after !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_done_pulse: done after DONE cycle got %b want 0", done_after);
        end
    endtask

    task automatic test_load_half_u;
        access(3'b110, 1'b0, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 3);
        n_tests++;
        if (o_be !== 4'b1100 || stall_cyc !== 4 || stable !== 1'b1) begin
            n_fail++;
            $display("FAIL lhu_bus: got be=%b stall_cycles=%0d stable=%b, want 1100 4 1", o_be, stall_cyc, stable);
        end
        n_tests++;
        if (o_rdata !== 32'h0000_BEEF || o_err !== 1'b0 || lat !== 4) begin
            n_fail++;
            $display("FAIL lhu_result: got rdata=%h err=%b lat=%0d, want 0000beef 0 4", o_rdata, o_err, lat);
        end
    endtask

    task automatic test_store_byte;
        access(3'b001, 1'b1, 32'h0000_0011, 32'h0000_00A5, 32'h1234_5678, 1);
        n_tests++;
        if ({o_we, o_be, o_wdata, o_addr} !== {1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0010}) begin
            n_fail++;
            $display("FAIL sb_bus: got we=%b be=%b wdata=%h addr=%h, want 1 0010 a5a5a5a5 00000010", o_we, o_be, o_wdata, o_addr);
        end
        n_tests++;
        if (got_done !== 1'b1 || o_rdata !== 32'd0 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_result: got done=%b rdata=%h err=%b, want 1 0 0", got_done, o_rdata, o_err);
        end
    endtask

    task automatic test_errors;
        access(3'b011, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1);
        n_tests++;
        if (req_cyc !== 0 || lat !== 1 || o_err !== 1'b1 || o_mis !== 1'b1 || stall_cyc !== 1) begin
            n_fail++;
            $display("FAIL lw_misaligned: got req_cycles=%0d lat=%0d err=%b mis=%b stall=%0d, want 0 1 1 1 1",
                     req_cyc, lat, o_err, o_mis, stall_cyc);
        end
        access(3'b100, 1'b0, 32'h0000_0008, 32'h0, 32'h0, 1);
        n_tests++;
        if (req_cyc !== 0 || lat !== 1 || o_err !== 1'b1 || o_mis !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_code: got req_cycles=%0d lat=%0d err=%b mis=%b, want 0 1 1 0", req_cyc, lat, o_err, o_mis);
        end
    endtask

    task automatic test_timeout;
        access(3'b011, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 0);
        n_tests++;
        if (req_cyc !== TO || lat !== TO + 1 || o_err !== 1'b1 || o_rdata !== 32'd0 || o_mis !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: got req_cycles=%0d lat=%0d err=%b rdata=%h mis=%b, want %0d %0d 1 0 0",
                     req_cyc, lat, o_err, o_rdata, o_mis, TO, TO + 1);
        end
        access(3'b011, 1'b0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, TO);
        n_tests++;
        if (lat !== TO + 1 || o_err !== 1'b0 || o_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL ack_at_limit: got lat=%0d err=%b rdata=%h, want %0d 0 cafef00d", lat, o_err, o_rdata, TO + 1);
        end
    endtask

    task automatic test_reset_mid_wait;
        int seen = 0;
        @(negedge clk);
        mem_code = 3'b011; is_store = 1'b0; addr = 32'h80; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        n_tests++;
        if (dmem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: req before reset got %b want 1", dmem_req);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({dmem_req, stall, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_async: got req=%b stall=%b done=%b, want 000", dmem_req, stall, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < TO + 4; i++) begin
            @(negedge clk);
            if (done || dmem_req) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rst_no_done: got %0d cycles with done/req, want 0", seen);
        end
    endtask

    task automatic test_ignored;
        int seen = 0;
        @(negedge clk);
        mem_code = 3'b000; is_store = 1'b0; addr = 32'h100; start = 1'b1;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL code0_stall: got %b want 0", stall);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || dmem_req || stall) seen++;
        end
        start = 1'b0;
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL code0_ignored: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        access(3'b011, 1'b1, 32'h0000_0200, 32'h1122_3344, 32'h0, 1);
        n_tests++;
        if (o_wdata !== 32'h1122_3344 || o_be !== 4'b1111 || lat !== 2) begin
            n_fail++;
            $display("FAIL b2b_store: got wdata=%h be=%b lat=%0d, want 11223344 1111 2", o_wdata, o_be, lat);
        end
        access(3'b010, 1'b0, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 2);
        n_tests++;
        if (o_rdata !== 32'hFFFF_8001 || lat !== 3 || o_be !== 4'b1100) begin
            n_fail++;
            $display("FAIL b2b_load: got rdata=%h lat=%0d be=%b, want ffff8001 3 1100", o_rdata, lat, o_be);
        end
    endtask

    task automatic test_random;
        logic [2:0]  codes [7] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b100, 3'b111};
        logic [2:0]  c;
        logic        st;
        logic [31:0] a, wd, rd;
        int          ack_at;
        logic        e;
        for (int i = 0; i < 40; i++) begin
            c = codes[$urandom_range(6, 0)];
            st = 1'($urandom);
            a = $urandom;
            if ($urandom_range(3, 0) != 0) a = a & 32'hFFFF_FFFC;
            wd = $urandom; rd = $urandom;
            ack_at = $urandom_range(4, 1);
            e = m_err(c, a);
            access(c, st, a, wd, rd, ack_at);
            n_tests++;
            if (o_err !== e || o_mis !== m_mis(c, a) ||
                o_rdata !== (e ? 32'd0 : m_rdata(c, st, a, rd)) ||
                lat !== (e ? 1 : ack_at + 1) || stall_cyc !== (e ? 1 : ack_at + 1)) begin
                n_fail++;
                $display("FAIL rand_result[%0d] code=%b st=%b a=%h: got err=%b mis=%b rdata=%h lat=%0d stall=%0d, want %b %b %h %0d %0d",
                         i, c, st, a, o_err, o_mis, o_rdata, lat, stall_cyc, e, m_mis(c, a),
                         e ? 32'd0 : m_rdata(c, st, a, rd), e ? 1 : ack_at + 1, e ? 1 : ack_at + 1);
            end
            if (!e) begin
                n_tests++;
                if (o_we !== st || o_addr !== {a[31:2], 2'b00} || o_be !== m_be(c, a) ||
                    (st && o_wdata !== m_wdata(c, wd)) || req_cyc !== ack_at || stable !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_bus[%0d] code=%b st=%b a=%h: got we=%b addr=%h be=%b wd=%h reqc=%0d stable=%b, want we=%b be=%b wd=%h reqc=%0d",
                             i, c, st, a, o_we, o_addr, o_be, o_wdata, req_cyc, stable,
                             st, m_be(c, a), m_wdata(c, wd), ack_at);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half_u();
        test_store_byte();
        test_errors();
        test_timeout();
        test_ignored();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
